byte_stripe_tx_gen: RTL and testbench
=====================================

Name: byte_stripe_tx_gen

Overview:
- Parametrised transmit-side byte striper for the multi-lane link.
- Accepts a serial stream of DATA_W-bit words with a valid/ready handshake and assembles them round-robin into rows of LANES words.
- Presents each complete row on all lanes simultaneously, with per-lane valid flags.
- Adds behaviour the fixed 4-lane striper lacks: end-of-packet flush with padding, output backpressure, and a rows-sent counter.

Parameters:
- DATA_W, 8, width of one lane word.
- LANES, 4, number of lanes; legal range 1..8.
- PAD_VAL, 0, DATA_W-bit value driven on unused lanes of a flushed partial row.
- PTR_W, clog2(LANES) (minimum 1), width of the lane pointer; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_last are valid.
- in_data  input  DATA_W  word to stripe.
- in_last  input  1  final word of a packet; flushes the current row.
- in_ready  output  1  block accepts a word this cycle.
- out_valid  output  1  out_data row is valid.
- out_ready  input  1  downstream consumes the row this cycle.
- out_data  output  LANES*DATA_W  row; lane i occupies bits [i*DATA_W +: DATA_W].
- out_lane_valid  output  LANES  lane i carries real data (bit 0 = lane 0).
- rows_sent  output  16  saturating count of rows consumed (out_valid && out_ready).

Behaviour:
- Reset (reset=0, async): state=FILL, lane pointer=0, row buffer=0, out_valid=0, out_data=0, out_lane_valid=0, rows_sent=0. in_ready is 1 after reset release.
- Reset mid-operation drops any partial row and any held row. No flush occurs.
- A word is accepted on a rising edge when in_valid && in_ready. It is written to row-buffer lane[ptr], and that lane's valid bit is set.
- Row completion: the accepted word has ptr==LANES-1, or in_last=1.
- On completion: ptr returns to 0, the row is marked complete, and lanes above ptr are filled with PAD_VAL with valid=0.
- Accepted words that do not complete a row increment ptr.
- State FILL: in_ready=1.
  - On completion, if the output register is free (out_valid=0, or out_valid && out_ready in the same cycle): load out_data and out_lane_valid, set out_valid=1, and stay in FILL.
  - Otherwise go to HOLD with the completed row held in the row buffer.
- State HOLD: in_ready=0.
  - When out_valid && out_ready: load the held row into the output register, out_valid remains 1, clear the row buffer, go to FILL.
- Output register: out_valid clears on out_valid && out_ready unless a new row loads the same edge.
- out_data, out_lane_valid and out_valid are stable while out_valid=1 && out_ready=0.
- Latency: a word completing a row at edge k with the register free gives out_valid=1 in cycle k+1.
- Back-to-back full throughput: one word per cycle sustained with out_ready=1, no bubbles.
- LANES=1: every accepted word completes a row. out_lane_valid is always 1 and in_last has no extra effect.
- in_last on a word at ptr==LANES-1: normal full row, no padding.
- in_last on the first word of a row: out_lane_valid=...0001.
- in_valid=0: ptr and the buffer hold. No timeout flush.
- rows_sent increments on each out_valid && out_ready and saturates at 16'hFFFF.
- All outputs are registered except in_ready, which decodes state directly.

Decomposition:
- Shared package/include byte_stripe_pkg holds:
  - the state encodings (FILL=0, HOLD=1, binary);
  - the clog2 function used for PTR_W;
  - the default PAD_VAL constant.
- One sub-module is natural: stripe_row_buf (DATA_W, LANES, PAD_VAL).
  - Contains the row buffer, lane pointer and valid bits.
  - Inputs: write enable, data, last, clear.
  - Outputs: complete, row, lane-valid.
- The top level holds the FSM, output register and counter.

Test Plan:
- LANES=4, out_ready=1, words 8'h11,22,33,44 on consecutive cycles -> one cycle after the 44 edge: out_valid=1, out_data=32'h44332211, out_lane_valid=4'b1111, rows_sent=1.
- Words 8'hA1,A2 with in_last on A2, PAD_VAL=8'h00 -> out_data=32'h0000A2A1, out_lane_valid=4'b0011; next row starts at lane 0.
- out_ready=0, feed 8 words 01..08 -> first row 04030201 holds on outputs. After 08, in_ready=0 (HOLD). Raise out_ready -> rows 04030201 then 08070605 appear on consecutive cycles, and in_ready=1 again.
- Continuous 16 words with out_ready=1 -> 4 rows on 4 consecutive valid cycles, no gap, rows_sent=4.
- Assert reset after 2 of 4 words with a row held -> all outputs 0, in_ready=1. Next words 55,66,77,88 -> out_data=32'h88776655, no stale data.
- LANES=1, DATA_W=8: words 9A,9B -> out_data 9A then 9B, out_lane_valid=1, one row per word.

Source files
------------

// File: rtl/byte_stripe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : byte_stripe_pkg
// Description : Shared FSM encodings, pointer-width helper and default pad
//               value for the byte striper.
// Revision    : 1.0 - initial release
// ============================================================================
package byte_stripe_pkg;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam int unsigned DEF_PAD_VAL = 0;

  // Ceiling log2, never below 1 so a single-lane build still has a pointer.
  function automatic int unsigned stripe_clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stripe_row_buf.sv
`default_nettype none
// ============================================================================
// Module      : stripe_row_buf
// Description : Row assembly buffer: lane pointer, lane words and lane valid
//               bits, with padding of unused lanes when a row completes.
// Revision    : 1.0 - initial release
// ============================================================================
module stripe_row_buf
  import byte_stripe_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       LANES   = 4,
  parameter logic [DATA_W-1:0] PAD_VAL = DATA_W'(DEF_PAD_VAL)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    last_i,
  input  logic                    clr_i,
  output logic                    complete_o,
  output logic [LANES*DATA_W-1:0] row_next_o,
  output logic [LANES-1:0]        lane_valid_next_o,
  output logic [LANES*DATA_W-1:0] row_o,
  output logic [LANES-1:0]        lane_valid_o
);

  localparam int unsigned      PTR_W    = stripe_clog2(LANES);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LANES - 1);

  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [LANES*DATA_W-1:0] row_q, row_d;
  logic [LANES-1:0]        lv_q, lv_d;
  logic                    w_complete;

  assign w_complete = wr_en_i && (last_i || (ptr_q == LAST_PTR));

  // Row as it will look after this write, padded above the pointer on completion.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [PTR_W-1:0] IDX = PTR_W'(i);
    logic w_wr, w_pad;
    assign w_wr  = wr_en_i && (ptr_q == IDX);
    assign w_pad = w_complete && (IDX > ptr_q);
    assign row_next_o[i*DATA_W +: DATA_W] = w_wr  ? data_i :
                                            w_pad ? PAD_VAL :
                                                    row_q[i*DATA_W +: DATA_W];
    assign lane_valid_next_o[i] = w_wr ? 1'b1 : (w_pad ? 1'b0 : lv_q[i]);
  end

  always_comb begin
    ptr_d = ptr_q;
    row_d = row_q;
    lv_d  = lv_q;
    if (clr_i) begin
      ptr_d = '0;
      row_d = '0;
      lv_d  = '0;
    end else if (wr_en_i) begin
      ptr_d = w_complete ? '0 : ptr_q + PTR_W'(1);
      row_d = row_next_o;
      lv_d  = lane_valid_next_o;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      row_q <= '0;
      lv_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      row_q <= row_d;
      lv_q  <= lv_d;
    end
  end

  assign complete_o   = w_complete;
  assign row_o        = row_q;
  assign lane_valid_o = lv_q;

endmodule
`default_nettype wire

// File: rtl/byte_stripe_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : byte_stripe_tx_gen
// Description : Transmit byte striper: round-robin row assembly, flush with
//               padding on in_last, output register with backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_stripe_tx_gen
  import byte_stripe_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       LANES   = 4,
  parameter logic [DATA_W-1:0] PAD_VAL = DATA_W'(DEF_PAD_VAL)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_lane_valid,
  output logic [15:0]             rows_sent
);

  logic [0:0]              state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]        out_lv_q, out_lv_d;
  logic [15:0]             rows_q, rows_d;

  logic                    w_accept, w_consume, w_free, w_complete;
  logic                    w_load_new, w_load_held, w_clr;
  logic [LANES*DATA_W-1:0] w_row_next, w_row_held;
  logic [LANES-1:0]        w_lv_next, w_lv_held;

  assign w_accept    = in_valid && in_ready;
  assign w_consume   = out_valid_q && out_ready;
  assign w_free      = !out_valid_q || out_ready;
  assign w_load_new  = (state_q == ST_FILL) && w_complete && w_free;
  assign w_load_held = (state_q == ST_HOLD) && w_consume;
  // A row that went straight to the output, or left the buffer, frees the buffer.
  assign w_clr       = w_load_new || w_load_held;

  stripe_row_buf #(
    .DATA_W  (DATA_W),
    .LANES   (LANES),
    .PAD_VAL (PAD_VAL)
  ) u_row_buf (
    .clk               (clk),
    .reset             (reset),
    .wr_en_i           (w_accept),
    .data_i            (in_data),
    .last_i            (in_last),
    .clr_i             (w_clr),
    .complete_o        (w_complete),
    .row_next_o        (w_row_next),
    .lane_valid_next_o (w_lv_next),
    .row_o             (w_row_held),
    .lane_valid_o      (w_lv_held)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (w_complete && !w_free) state_d = ST_HOLD;
      ST_HOLD: if (w_consume)             state_d = ST_FILL;
      default:                            state_d = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_FILL);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lv_d    = out_lv_q;
    if (w_load_new) begin
      out_valid_d = 1'b1;
      out_data_d  = w_row_next;
      out_lv_d    = w_lv_next;
    end else if (w_load_held) begin
      out_valid_d = 1'b1;
      out_data_d  = w_row_held;
      out_lv_d    = w_lv_held;
    end else if (w_consume) begin
      out_valid_d = 1'b0;
    end
    rows_d = (w_consume && (rows_q != 16'hFFFF)) ? rows_q + 16'd1 : rows_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lv_q    <= '0;
      rows_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lv_q    <= out_lv_d;
      rows_q      <= rows_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_lane_valid = out_lv_q;
  assign rows_sent      = rows_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_stripe_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_stripe_tx_gen
// Description : Self-checking bench: directed vector table, multi-cycle
//               sequences and a randomized run against a row-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_stripe_tx_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic        ir4, ov4;
  logic [31:0] od4;
  logic [3:0]  lv4;
  logic [15:0] rs4;
  logic        ir1, ov1;
  logic [7:0]  od1;
  logic [0:0]  lv1;
  logic [15:0] rs1;
  logic        ir3, ov3;
  logic [23:0] od3;
  logic [2:0]  lv3;
  logic [15:0] rs3;

  always #5 clk = ~clk;

  byte_stripe_tx_gen #(.DATA_W(8), .LANES(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(ir4), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .out_lane_valid(lv4), .rows_sent(rs4));

  byte_stripe_tx_gen #(.DATA_W(8), .LANES(1)) u_one (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(ir1), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_lane_valid(lv1), .rows_sent(rs1));

  byte_stripe_tx_gen #(.DATA_W(8), .LANES(3), .PAD_VAL(8'hEE)) u_pad (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(ir3), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
    .out_lane_valid(lv3), .rows_sent(rs3));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserted between edges so the checks see the asynchronous clear.
  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    chk("rst_out_valid", ov4, 0);
    chk("rst_out_data", od4, 0);
    chk("rst_lane_valid", lv4, 0);
    chk("rst_rows_sent", rs4, 0);
    chk("rst_in_ready", ir4, 1);
    tick();
    reset = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        rdy;
    logic        eov;
    logic [31:0] edat;
    logic [3:0]  elv;
    logic        eir;
    logic [15:0] ers;
  } vec_t;

  vec_t tbl[25];

  typedef struct {
    logic [31:0] d;
    logic [3:0]  lv;
  } row_t;

  row_t       mq[$];
  logic [7:0] cur[$];
  row_t       r;
  int         cnt;
  logic       acc, cons;

  initial begin
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 16'd0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 16'd0};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 16'd0};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b1, 16'd0};
    tbl[4]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 16'd1};
    tbl[5]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 32'h0000A2A1, 4'h3, 1'b1, 16'd1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 16'd2};
    tbl[7]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 16'd2};
    tbl[8]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 16'd2};
    tbl[9]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 16'd2};
    tbl[10] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b1, 16'd2};
    tbl[11] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b1, 16'd2};
    tbl[12] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b1, 16'd2};
    tbl[13] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b1, 16'd2};
    tbl[14] = '{1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0, 16'd2};
    tbl[15] = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0, 16'd2};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h08070605, 4'hF, 1'b1, 16'd3};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 16'd4};
    tbl[18] = '{1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 32'h000000B1, 4'h1, 1'b1, 16'd4};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 16'd5};
    tbl[20] = '{1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 16'd5};
    tbl[21] = '{1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 16'd5};
    tbl[22] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 16'd5};
    tbl[23] = '{1'b1, 8'hC4, 1'b1, 1'b1, 1'b1, 32'hC4C3C2C1, 4'hF, 1'b1, 16'd5};
    tbl[24] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 16'd6};

    #1;
    do_reset();

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rdy);
      tick();
      chk($sformatf("vec%0d_out_valid", i), ov4, tbl[i].eov);
      chk($sformatf("vec%0d_in_ready", i), ir4, tbl[i].eir);
      chk($sformatf("vec%0d_rows_sent", i), rs4, tbl[i].ers);
      if (tbl[i].eov) begin
        chk($sformatf("vec%0d_out_data", i), od4, tbl[i].edat);
        chk($sformatf("vec%0d_lane_valid", i), lv4, tbl[i].elv);
      end
    end

    // Sustained stream: 4 lanes never stall, 1 lane emits a row every cycle.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i * 7 + 3), 1'b0, 1'b1);
      tick();
      chk($sformatf("stream%0d_in_ready", i), ir4, 1);
      chk($sformatf("stream%0d_one_valid", i), ov1, 1);
      chk($sformatf("stream%0d_one_data", i), od1, 8'(i * 7 + 3));
      if (i > 0) chk($sformatf("stream%0d_one_rows", i), rs1, i);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    tick();
    chk("stream_rows_sent", rs4, 4);
    chk("stream_one_rows", rs1, 16);

    // Single-lane flush has no effect; 3-lane instance pads with its own value.
    do_reset();
    drive(1'b1, 8'h9A, 1'b0, 1'b1);
    tick();
    chk("one_9A_data", od1, 8'h9A);
    chk("one_9A_lv", lv1, 1);
    drive(1'b1, 8'h9B, 1'b1, 1'b1);
    tick();
    chk("one_9B_data", od1, 8'h9B);
    chk("one_9B_lv", lv1, 1);
    chk("pad_valid", ov3, 1);
    chk("pad_data", od3, 24'hEE9B9A);
    chk("pad_lv", lv3, 3'b011);
    chk("pad_in_ready", ir3, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("one_idle_valid", ov1, 0);
    chk("one_rows", rs1, 2);

    // Reset with a held row and a partial row in flight.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h21 + 8'(i), 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("pre_rst_rows", rs4, 1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    chk("pre_rst_held", od4, 32'h34333231);
    do_reset();
    chk("post_rst_in_ready", ir4, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h55 + 8'(i) * 8'h11, 1'b0, 1'b1);
      tick();
    end
    chk("post_rst_valid", ov4, 1);
    chk("post_rst_data", od4, 32'h88776655);
    chk("post_rst_lv", lv4, 4'hF);

    // Randomized run: pending rows modelled as a queue of at most two.
    do_reset();
    mq.delete();
    cur.delete();
    cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      drive(($urandom_range(3) != 0), 8'($urandom), ($urandom_range(4) == 0),
            ($urandom_range(2) != 0));
      acc  = in_valid && (mq.size() < 2);
      cons = out_ready && (mq.size() > 0);
      tick();
      if (cons) begin
        mq.delete(0);
        cnt++;
      end
      if (acc) begin
        cur.push_back(in_data);
        if (in_last || (cur.size() == 4)) begin
          r.d  = '0;
          r.lv = '0;
          foreach (cur[k]) begin
            r.d[k*8 +: 8] = cur[k];
            r.lv[k]       = 1'b1;
          end
          mq.push_back(r);
          cur.delete();
        end
      end
      chk("rnd_in_ready", ir4, (mq.size() < 2));
      chk("rnd_out_valid", ov4, (mq.size() > 0));
      chk("rnd_rows_sent", rs4, (cnt > 65535) ? 65535 : cnt);
      if (mq.size() > 0) begin
        chk("rnd_out_data", od4, mq[0].d);
        chk("rnd_lane_valid", lv4, mq[0].lv);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
